// File: rtl/wsp_pkg.sv
// rtl/wsp_pkg.sv - shared WSP types and WIR opcode constants
package wsp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_SHIFT,
      ST_UPDATE,
      ST_DONE,
      ST_ABORT
   } wir_state_e;

   localparam int WIR_LEN_DEF = 3;

   localparam logic [WIR_LEN_DEF-1:0] OP_BYPASS = 3'b111;
   localparam logic [WIR_LEN_DEF-1:0] OP_EXTEST = 3'b001;
   localparam logic [WIR_LEN_DEF-1:0] OP_INTEST = 3'b010;

endpackage

// File: rtl/wir_loader.sv
// rtl/wir_loader.sv - capture/shift/update sequencer for the WIR chain
module wir_loader
   import wsp_pkg::*;
#(
   parameter int WIR_LEN = WIR_LEN_DEF,
   parameter int CNT_W   = $clog2(WIR_LEN + 1)
) (
   input  logic               WRCK,
   input  logic               WRSTN,
   input  logic               start,
   input  logic               abort,
   input  logic [WIR_LEN-1:0] instr,
   input  logic               wir_so,
   output logic               wir_capture,
   output logic               wir_shift,
   output logic               wir_update,
   output logic               wir_si,
   output logic               select_wir,
   output logic               busy,
   output logic               done,
   output logic               aborted,
   output logic [WIR_LEN-1:0] captured
);

   wir_state_e         state_q;
   wir_state_e         state_d;
   logic [WIR_LEN-1:0] sh_q;
   logic [WIR_LEN-1:0] sh_d;
   logic [CNT_W-1:0]   cnt_q;

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_CAPTURE;
               sh_d    = instr;
            end
         end
         ST_CAPTURE: state_d = abort ? ST_ABORT : ST_SHIFT;
         ST_SHIFT: begin
            if (abort) begin
               state_d = ST_ABORT;
            end else begin
               sh_d = sh_q >> 1;
               if (cnt_q == CNT_W'(WIR_LEN - 1)) state_d = ST_UPDATE;
            end
         end
         ST_UPDATE: state_d = ST_DONE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so each flop holds its value for the whole state.
   always_ff @(posedge WRCK or negedge WRSTN) begin
      if (!WRSTN) begin
         state_q     <= ST_IDLE;
         sh_q        <= '0;
         cnt_q       <= '0;
         captured    <= '0;
         wir_capture <= 1'b0;
         wir_shift   <= 1'b0;
         wir_update  <= 1'b0;
         wir_si      <= 1'b0;
         select_wir  <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         aborted     <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         if (state_q == ST_IDLE && start) begin
            cnt_q    <= '0;
            captured <= '0;
         end else if (state_q == ST_SHIFT && !abort) begin
            for (int i = 0; i < WIR_LEN; i++) begin
               if (cnt_q == CNT_W'(i)) captured[i] <= wir_so;
            end
            cnt_q <= cnt_q + CNT_W'(1);
         end
         wir_capture <= (state_d == ST_CAPTURE);
         wir_shift   <= (state_d == ST_SHIFT);
         wir_update  <= (state_d == ST_UPDATE);
         wir_si      <= (state_d == ST_SHIFT) && sh_d[0];
         select_wir  <= (state_d == ST_CAPTURE) || (state_d == ST_SHIFT) ||
                        (state_d == ST_UPDATE)  || (state_d == ST_ABORT);
         busy        <= (state_d == ST_CAPTURE) || (state_d == ST_SHIFT) ||
                        (state_d == ST_UPDATE);
         done        <= (state_d == ST_DONE);
         aborted     <= (state_d == ST_ABORT);
      end
   end

endmodule
